rvvi_obi_tap: RTL and testbench

//  Upstream feeder of the RVVI bus monitor. Snoops the core's OBI instruction and data

---
 rtl/rvvi_obi_tap_if.sv | 37 +++
 rtl/rvvi_obi_tap.sv | 140 ++++++++++++++
 tb/tb_rvvi_obi_tap.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvvi_obi_tap_if.sv
// OBI instruction and data port signals as seen between core and memory.
// The tap observes every signal through the monitor modport.
interface rvvi_obi_tap_if;
  logic        instr_req_i;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        data_req_i;
  logic        data_gnt_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport monitor (
    input instr_req_i, instr_gnt_i, instr_addr_i, instr_rvalid_i, instr_rdata_i,
    input data_req_i, data_gnt_i, data_we_i, data_be_i, data_addr_i,
    input data_wdata_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/rvvi_obi_tap.sv
// Passive OBI snooper: pairs each rvalid with its granted request via
// per-port outstanding-request FIFOs and emits one-cycle RVVI strobes.
module rvvi_obi_tap #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  rvvi_obi_tap_if.monitor      obi,
  output logic                 Ird,
  output logic [31:0]          IAddr,
  output logic [31:0]          IData,
  output logic [3:0]           Ibe,
  output logic [2:0]           ISize,
  output logic                 Drd,
  output logic                 Dwr,
  output logic [31:0]          DAddr,
  output logic [31:0]          DData,
  output logic [3:0]           Dbe,
  output logic [2:0]           DSize,
  output logic                 proto_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } d_entry_t;

  logic [31:0] i_mem [DEPTH];
  d_entry_t    d_mem [DEPTH];

  logic [AW:0] i_wr, i_rd, d_wr, d_rd;

  logic i_empty, i_full, i_push_req, i_pop, i_push, i_ovf, i_unf;
  logic d_empty, d_full, d_push_req, d_pop, d_push, d_ovf, d_unf;
  logic [31:0] i_head;
  d_entry_t    d_head;
  logic [2:0]  d_size;
  logic        d_be_bad;
  logic        err_set;

  // FIFO status, push/pop qualification and error detection.
  // A grant while full is accepted only if a pop frees the head slot in the same cycle.
  always_comb begin
    i_empty    = (i_wr == i_rd);
    i_full     = (i_wr[AW] != i_rd[AW]) && (i_wr[AW-1:0] == i_rd[AW-1:0]);
    i_push_req = obi.instr_req_i & obi.instr_gnt_i;
    i_pop      = obi.instr_rvalid_i & ~i_empty;
    i_push     = i_push_req & (~i_full | i_pop);
    i_ovf      = i_push_req & i_full & ~i_pop;
    i_unf      = obi.instr_rvalid_i & i_empty;
    i_head     = i_mem[i_rd[AW-1:0]];

    d_empty    = (d_wr == d_rd);
    d_full     = (d_wr[AW] != d_rd[AW]) && (d_wr[AW-1:0] == d_rd[AW-1:0]);
    d_push_req = obi.data_req_i & obi.data_gnt_i;
    d_pop      = obi.data_rvalid_i & ~d_empty;
    d_push     = d_push_req & (~d_full | d_pop);
    d_ovf      = d_push_req & d_full & ~d_pop;
    d_unf      = obi.data_rvalid_i & d_empty;
    d_head     = d_mem[d_rd[AW-1:0]];
  end

  // Byte count from the popped entry's enables; non-contiguous or empty masks are errors.
  always_comb begin
    d_size   = '0;
    d_be_bad = 1'b0;
    unique case (d_head.be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: d_size = 3'd1;
      4'b0011, 4'b1100:                   d_size = 3'd2;
      4'b1111:                            d_size = 3'd4;
      default:                            d_be_bad = 1'b1;
    endcase
    err_set = i_ovf | i_unf | d_ovf | d_unf | (d_pop & d_be_bad);
  end

  // Outstanding-request storage; contents are don't-care until pointed to.
  always_ff @(posedge Clk) begin
    if (i_push) i_mem[i_wr[AW-1:0]] <= obi.instr_addr_i;
    if (d_push) d_mem[d_wr[AW-1:0]] <= '{addr:  obi.data_addr_i,
                                          we:    obi.data_we_i,
                                          be:    obi.data_be_i,
                                          wdata: obi.data_wdata_i};
  end

  // FIFO pointers; reset discards all in-flight entries.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      i_wr <= '0;
      i_rd <= '0;
      d_wr <= '0;
      d_rd <= '0;
    end else begin
      if (i_push) i_wr <= i_wr + PTR_ONE;
      if (i_pop)  i_rd <= i_rd + PTR_ONE;
      if (d_push) d_wr <= d_wr + PTR_ONE;
      if (d_pop)  d_rd <= d_rd + PTR_ONE;
    end
  end

  // Registered RVVI strobes and payload; payload holds between strobes, error is sticky.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Ird         <= 1'b0;
      IAddr       <= '0;
      IData       <= '0;
      Ibe         <= '0;
      ISize       <= '0;
      Drd         <= 1'b0;
      Dwr         <= 1'b0;
      DAddr       <= '0;
      DData       <= '0;
      Dbe         <= '0;
      DSize       <= '0;
      proto_err_o <= 1'b0;
    end else begin
      Ird <= i_pop;
      Drd <= d_pop & ~d_head.we;
      Dwr <= d_pop & d_head.we;
      if (i_pop) begin
        IAddr <= i_head;
        IData <= obi.instr_rdata_i;
        Ibe   <= 4'hF;
        ISize <= 3'd4;
      end
      if (d_pop) begin
        DAddr <= d_head.addr;
        DData <= d_head.we ? d_head.wdata : obi.data_rdata_i;
        Dbe   <= d_head.be;
        DSize <= d_size;
      end
      if (err_set) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rvvi_obi_tap.sv
// Directed bench for rvvi_obi_tap: a vector table for single-cycle behaviour
// plus hand-written sequences for pipelining, full/wrap, empty and async reset.
module tb_rvvi_obi_tap;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Ird, Drd, Dwr, proto_err_o;
  logic [31:0] IAddr, IData, DAddr, DData;
  logic [3:0]  Ibe, Dbe;
  logic [2:0]  ISize, DSize;

  int errors = 0;
  int checks = 0;

  rvvi_obi_tap_if obi ();

  rvvi_obi_tap #(.DEPTH(4)) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .obi         (obi),
    .Ird         (Ird),
    .IAddr       (IAddr),
    .IData       (IData),
    .Ibe         (Ibe),
    .ISize       (ISize),
    .Drd         (Drd),
    .Dwr         (Dwr),
    .DAddr       (DAddr),
    .DData       (DData),
    .Dbe         (Dbe),
    .DSize       (DSize),
    .proto_err_o (proto_err_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ireq;   logic [31:0] iaddr;  logic irv;  logic [31:0] irdata;
    logic        dreq;   logic        dwe;    logic [3:0] dbe;
    logic [31:0] daddr;  logic [31:0] dwdata; logic drv;  logic [31:0] drdata;
    logic        e_ird;  logic [31:0] e_iaddr; logic [31:0] e_idata; logic [3:0] e_ibe; logic [2:0] e_isize;
    logic        e_drd;  logic        e_dwr;   logic [31:0] e_daddr; logic [31:0] e_ddata;
    logic [3:0]  e_dbe;  logic [2:0]  e_dsize; logic        e_err;
  } vec_t;

  vec_t vt [11];
  logic [31:0] drain_exp [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    obi.instr_req_i    = 1'b0;
    obi.instr_gnt_i    = 1'b0;
    obi.instr_addr_i   = '0;
    obi.instr_rvalid_i = 1'b0;
    obi.instr_rdata_i  = '0;
    obi.data_req_i     = 1'b0;
    obi.data_gnt_i     = 1'b0;
    obi.data_we_i      = 1'b0;
    obi.data_be_i      = '0;
    obi.data_addr_i    = '0;
    obi.data_wdata_i   = '0;
    obi.data_rvalid_i  = 1'b0;
    obi.data_rdata_i   = '0;
  endtask

  task automatic reset_dut();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic data_grant(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    obi.data_req_i   = 1'b1;
    obi.data_gnt_i   = 1'b1;
    obi.data_we_i    = we;
    obi.data_be_i    = be;
    obi.data_addr_i  = addr;
    obi.data_wdata_i = wdata;
  endtask

  task automatic data_resp(input logic [31:0] rdata);
    obi.data_rvalid_i = 1'b1;
    obi.data_rdata_i  = rdata;
  endtask

  initial begin
    // ireq,iaddr,irv,irdata, dreq,dwe,dbe,daddr,dwdata,drv,drdata,
    // e_ird,e_iaddr,e_idata,e_ibe,e_isize, e_drd,e_dwr,e_daddr,e_ddata,e_dbe,e_dsize,e_err
    vt[0]  = '{0, 0, 0, 0,      0, 0, 4'h0, 0, 0, 0, 0,
               0, 0, 0, 4'h0, 3'd0,  0, 0, 0, 0, 4'h0, 3'd0, 0};
    vt[1]  = '{0, 0, 0, 0,      1, 0, 4'hF, 32'h1000, 0, 0, 0,
               0, 0, 0, 4'h0, 3'd0,  0, 0, 0, 0, 4'h0, 3'd0, 0};
    vt[2]  = '{0, 0, 0, 0,      0, 0, 4'h0, 0, 0, 0, 0,
               0, 0, 0, 4'h0, 3'd0,  0, 0, 0, 0, 4'h0, 3'd0, 0};
    vt[3]  = '{0, 0, 0, 0,      0, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF,
               0, 0, 0, 4'h0, 3'd0,  1, 0, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd4, 0};
    vt[4]  = '{0, 0, 0, 0,      1, 1, 4'h8, 32'h2003, 32'h41000000, 0, 0,
               0, 0, 0, 4'h0, 3'd0,  0, 0, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd4, 0};
    vt[5]  = '{0, 0, 0, 0,      0, 0, 4'h0, 0, 0, 1, 32'h12345678,
               0, 0, 0, 4'h0, 3'd0,  0, 1, 32'h2003, 32'h41000000, 4'h8, 3'd1, 0};
    vt[6]  = '{1, 32'h400, 0, 0, 1, 0, 4'hC, 32'h3002, 0, 0, 0,
               0, 0, 0, 4'h0, 3'd0,  0, 0, 32'h2003, 32'h41000000, 4'h8, 3'd1, 0};
    vt[7]  = '{0, 0, 1, 32'h13, 0, 0, 4'h0, 0, 0, 1, 32'hAAAA0000,
               1, 32'h400, 32'h13, 4'hF, 3'd4,  1, 0, 32'h3002, 32'hAAAA0000, 4'hC, 3'd2, 0};
    vt[8]  = '{0, 0, 0, 0,      0, 0, 4'h0, 0, 0, 0, 0,
               0, 32'h400, 32'h13, 4'hF, 3'd4,  0, 0, 32'h3002, 32'hAAAA0000, 4'hC, 3'd2, 0};
    vt[9]  = '{0, 0, 0, 0,      1, 0, 4'h5, 32'h4000, 0, 0, 0,
               0, 32'h400, 32'h13, 4'hF, 3'd4,  0, 0, 32'h3002, 32'hAAAA0000, 4'hC, 3'd2, 0};
    vt[10] = '{0, 0, 0, 0,      0, 0, 4'h0, 0, 0, 1, 32'h55,
               0, 32'h400, 32'h13, 4'hF, 3'd4,  1, 0, 32'h4000, 32'h55, 4'h5, 3'd0, 1};

    drain_exp[0] = 32'h10C;
    drain_exp[1] = 32'h300;
    drain_exp[2] = 32'h304;
    drain_exp[3] = 32'h308;

    reset_dut();

    // Table: one vector per cycle, outputs checked just after the edge it feeds.
    for (int i = 0; i < 11; i++) begin
      obi.instr_req_i    = vt[i].ireq;
      obi.instr_gnt_i    = vt[i].ireq;
      obi.instr_addr_i   = vt[i].iaddr;
      obi.instr_rvalid_i = vt[i].irv;
      obi.instr_rdata_i  = vt[i].irdata;
      obi.data_req_i     = vt[i].dreq;
      obi.data_gnt_i     = vt[i].dreq;
      obi.data_we_i      = vt[i].dwe;
      obi.data_be_i      = vt[i].dbe;
      obi.data_addr_i    = vt[i].daddr;
      obi.data_wdata_i   = vt[i].dwdata;
      obi.data_rvalid_i  = vt[i].drv;
      obi.data_rdata_i   = vt[i].drdata;
      tick();
      chk($sformatf("vec%0d_Ird", i),   32'(Ird),         32'(vt[i].e_ird));
      chk($sformatf("vec%0d_IAddr", i), IAddr,            vt[i].e_iaddr);
      chk($sformatf("vec%0d_IData", i), IData,            vt[i].e_idata);
      chk($sformatf("vec%0d_Ibe", i),   32'(Ibe),         32'(vt[i].e_ibe));
      chk($sformatf("vec%0d_ISize", i), 32'(ISize),       32'(vt[i].e_isize));
      chk($sformatf("vec%0d_Drd", i),   32'(Drd),         32'(vt[i].e_drd));
      chk($sformatf("vec%0d_Dwr", i),   32'(Dwr),         32'(vt[i].e_dwr));
      chk($sformatf("vec%0d_DAddr", i), DAddr,            vt[i].e_daddr);
      chk($sformatf("vec%0d_DData", i), DData,            vt[i].e_ddata);
      chk($sformatf("vec%0d_Dbe", i),   32'(Dbe),         32'(vt[i].e_dbe));
      chk($sformatf("vec%0d_DSize", i), 32'(DSize),       32'(vt[i].e_dsize));
      chk($sformatf("vec%0d_err", i),   32'(proto_err_o), 32'(vt[i].e_err));
    end

    // Pipelined fetches: four grants then four back-to-back responses.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      idle();
      obi.instr_req_i  = 1'b1;
      obi.instr_gnt_i  = 1'b1;
      obi.instr_addr_i = 32'h80 + 32'(4 * i);
      tick();
      chk($sformatf("fetch_gnt%0d_Ird", i), 32'(Ird), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      obi.instr_rvalid_i = 1'b1;
      obi.instr_rdata_i  = 32'hA000 + 32'(i);
      tick();
      chk($sformatf("fetch_rsp%0d_Ird", i),   32'(Ird), 32'd1);
      chk($sformatf("fetch_rsp%0d_IAddr", i), IAddr,    32'h80 + 32'(4 * i));
      chk($sformatf("fetch_rsp%0d_IData", i), IData,    32'hA000 + 32'(i));
    end
    idle();
    tick();
    chk("fetch_end_Ird", 32'(Ird), 32'd0);
    chk("fetch_end_err", 32'(proto_err_o), 32'd0);

    // Full FIFO, dropped fifth grant, then pop+push rounds across the pointer wrap.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      idle();
      data_grant(1'b0, 4'hF, 32'h100 + 32'(4 * i), '0);
      tick();
      chk($sformatf("fill%0d_err", i), 32'(proto_err_o), 32'd0);
    end
    idle();
    data_grant(1'b0, 4'hF, 32'h200, '0);
    tick();
    chk("overflow_err", 32'(proto_err_o), 32'd1);
    chk("overflow_Drd", 32'(Drd), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      data_grant(1'b0, 4'hF, 32'h300 + 32'(4 * k), '0);
      data_resp(32'hB0 + 32'(k));
      tick();
      chk($sformatf("wrap%0d_Drd", k),   32'(Drd), 32'd1);
      chk($sformatf("wrap%0d_DAddr", k), DAddr,    32'h100 + 32'(4 * k));
      chk($sformatf("wrap%0d_DData", k), DData,    32'hB0 + 32'(k));
    end
    for (int j = 0; j < 4; j++) begin
      idle();
      data_resp(32'hC0 + 32'(j));
      tick();
      chk($sformatf("drain%0d_Drd", j),   32'(Drd), 32'd1);
      chk($sformatf("drain%0d_DAddr", j), DAddr,    drain_exp[j]);
      chk($sformatf("drain%0d_DData", j), DData,    32'hC0 + 32'(j));
    end
    idle();
    data_resp(32'hEE);
    tick();
    chk("drained_empty_Drd", 32'(Drd), 32'd0);
    chk("drained_empty_DAddr", DAddr, 32'h308);

    // Responses with nothing outstanding: no strobe, sticky error.
    reset_dut();
    chk("empty_reset_err", 32'(proto_err_o), 32'd0);
    chk("empty_reset_DAddr", DAddr, 32'd0);
    idle();
    obi.instr_rvalid_i = 1'b1;
    data_resp(32'h99);
    tick();
    chk("empty_Drd", 32'(Drd), 32'd0);
    chk("empty_Ird", 32'(Ird), 32'd0);
    chk("empty_err", 32'(proto_err_o), 32'd1);
    idle();
    tick();
    tick();
    tick();
    chk("empty_err_held", 32'(proto_err_o), 32'd1);

    // Async reset with two requests still outstanding.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      idle();
      data_grant(1'b0, 4'hF, 32'h500 + 32'(4 * i), '0);
      tick();
    end
    idle();
    data_resp(32'h77);
    tick();
    chk("pre_rst_Drd", 32'(Drd), 32'd1);
    chk("pre_rst_DAddr", DAddr, 32'h500);
    idle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_Drd", 32'(Drd), 32'd0);
    chk("async_rst_DAddr", DAddr, 32'd0);
    chk("async_rst_DData", DData, 32'd0);
    chk("async_rst_DSize", 32'(DSize), 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    chk("post_rst_err", 32'(proto_err_o), 32'd0);
    data_resp(32'h88);
    tick();
    chk("post_rst_rsp_Drd", 32'(Drd), 32'd0);
    chk("post_rst_rsp_err", 32'(proto_err_o), 32'd1);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
